// File: rtl/lm_encoder_pkg.sv
// Shared constants and FSM encoding for the LED-manager write path.
package lm_encoder_pkg;

    localparam int WIDTH_LEDS     = 8;
    localparam int LM_HOLD_CYCLES = 50_000_000;

    typedef enum logic [1:0] {
        LM_S_IDLE     = 2'd0,
        LM_S_HOLD     = 2'd1,
        LM_S_ERR_LOCK = 2'd2
    } lm_state_t;

endpackage

// File: rtl/lm_encoder_pending_slot.sv
// One-deep pending event register: set wins over clear, and a set on an
// occupied slot that is not being cleared reports an overwrite.
module lm_pending_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic [WIDTH-1:0] set_word,
    input  logic             clr,
    output logic             valid,
    output logic [WIDTH-1:0] word,
    output logic             overwrite
);

    // A set in the same cycle as the issuing clear is a fresh event, not a loss.
    assign overwrite = set && valid && !clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            word  <= '0;
        end else if (set) begin
            valid <= 1'b1;
            word  <= set_word;
        end else if (clr) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lm_encoder.sv
// LED word encoder: captures error/data/act events, arbitrates them by priority
// and pushes one word per hold period into the LED FIFO.
module lm_encoder
    import lm_encoder_pkg::*;
#(
    parameter int WIDTH       = WIDTH_LEDS,
    parameter int HOLD_CYCLES = LM_HOLD_CYCLES,
    parameter bit ERR_STICKY  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             err_valid,
    input  logic [WIDTH-1:0] err_code,
    input  logic             data_valid,
    input  logic [WIDTH-1:0] data_word,
    input  logic             act_pulse,
    input  logic             err_clr,
    input  logic             fifo_full,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_data,
    output logic             err_locked,
    output logic             dropped
);

    localparam int               CNT_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    lm_state_t        state;
    logic [CNT_W-1:0] hold_cnt;
    logic [WIDTH-1:0] act_cnt;
    logic [WIDTH-1:0] act_next;
    logic             last_err;

    logic             err_v, data_v, act_v;
    logic [WIDTH-1:0] err_w, data_w, act_w;
    logic             err_ov, data_ov, act_ov;

    logic             enter_lock;
    logic             blocked;
    logic             issue_err, issue_data, issue_act, issue;
    logic [WIDTH-1:0] issue_word;
    logic             drop_any;

    // FIFO handshake: wr_en is a one-cycle push raised only after an edge at
    // which fifo_full was low; the word stays on wr_data until the next push.
    always_comb begin
        act_next   = act_cnt + 1'b1;
        enter_lock = ERR_STICKY && (state == LM_S_HOLD) && (hold_cnt == '0) && last_err;
        blocked    = (state == LM_S_ERR_LOCK) || enter_lock;
        issue_err  = 1'b0;
        issue_data = 1'b0;
        issue_act  = 1'b0;
        if (!fifo_full) begin
            if (state == LM_S_IDLE) begin
                if (err_v)       issue_err  = 1'b1;
                else if (data_v) issue_data = 1'b1;
                else if (act_v)  issue_act  = 1'b1;
            end else if (state == LM_S_ERR_LOCK && !err_clr) begin
                issue_err = err_v;
            end
        end
        issue      = issue_err || issue_data || issue_act;
        issue_word = issue_err ? err_w : (issue_data ? data_w : act_w);
        drop_any   = err_ov || data_ov || act_ov
                   || (blocked && (data_valid || act_pulse))
                   || (enter_lock && (data_v || act_v));
    end

    lm_pending_slot #(.WIDTH(WIDTH)) u_err_slot (
        .clk       (clk),
        .rst       (rst),
        .set       (err_valid),
        .set_word  (err_code),
        .clr       (issue_err),
        .valid     (err_v),
        .word      (err_w),
        .overwrite (err_ov)
    );

    lm_pending_slot #(.WIDTH(WIDTH)) u_data_slot (
        .clk       (clk),
        .rst       (rst),
        .set       (data_valid && !blocked),
        .set_word  (data_word),
        .clr       (issue_data || enter_lock),
        .valid     (data_v),
        .word      (data_w),
        .overwrite (data_ov)
    );

    lm_pending_slot #(.WIDTH(WIDTH)) u_act_slot (
        .clk       (clk),
        .rst       (rst),
        .set       (act_pulse && !blocked),
        .set_word  (act_next),
        .clr       (issue_act || enter_lock),
        .valid     (act_v),
        .word      (act_w),
        .overwrite (act_ov)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LM_S_IDLE;
            hold_cnt   <= '0;
            act_cnt    <= '0;
            last_err   <= 1'b0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            err_locked <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            wr_en   <= issue;
            dropped <= drop_any;
            if (issue) begin
                wr_data  <= issue_word;
                last_err <= issue_err;
            end
            if (act_pulse) act_cnt <= act_next;

            case (state)
                LM_S_IDLE: begin
                    if (issue) begin
                        hold_cnt <= HOLD_LOAD;
                        state    <= LM_S_HOLD;
                    end
                end
                LM_S_HOLD: begin
                    if (hold_cnt == '0) begin
                        state      <= enter_lock ? LM_S_ERR_LOCK : LM_S_IDLE;
                        err_locked <= enter_lock;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                LM_S_ERR_LOCK: begin
                    // Clearing takes precedence; a pending error then issues from IDLE.
                    if (err_clr) begin
                        state      <= LM_S_IDLE;
                        err_locked <= 1'b0;
                    end else if (issue) begin
                        hold_cnt   <= HOLD_LOAD;
                        state      <= LM_S_HOLD;
                        err_locked <= 1'b0;
                    end
                end
                default: begin
                    state      <= LM_S_IDLE;
                    err_locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
